bist_pattern_gen: RTL and testbench
===================================

BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

Interface
REQ-001 Parameter ADDR_WIDTH, 4, width of pattern address.
REQ-002 Parameter SCAN_LENGTH, 4, scan chain length and pattern word width, range 2..16.
REQ-003 Parameter NUM_PATTERNS, 2**ADDR_WIDTH, number of patterns per run, range 1..2**ADDR_WIDTH.
REQ-004 Parameter SEED, 1, first pattern word, nonzero.
REQ-005 Parameter TAPS, 4'hC, Galois LFSR feedback mask, SCAN_LENGTH bits wide.
REQ-006 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 Port rst, input, 1, synchronous, active-high reset.
REQ-008 Port start, input, 1, run request, same pulse the BIST controller samples.
REQ-009 Port scan_en, input, 1, shift strobe from controller.
REQ-010 Port addr_en, input, 1, advance-to-next-pattern strobe from controller.
REQ-011 Port done, input, 1, controller run-complete flag.
REQ-012 Port scan_in, output, 1, serial bit to scan chain, equal to shift register bit 0.
REQ-013 Port pattern_word, output, SCAN_LENGTH, current unrotated pattern, used as golden reference.
REQ-014 Port pattern_addr, output, ADDR_WIDTH, index of current pattern.
REQ-015 Port last_pattern, output, 1, high when pattern_addr == NUM_PATTERNS-1 and state is ACTIVE; drives controller last_pattern.
REQ-016 Port shift_cnt, output, clog2(SCAN_LENGTH), shifts taken modulo SCAN_LENGTH.
REQ-017 Port busy, output, 1, high in ACTIVE.
REQ-018 Port overrun, output, 1, sticky: addr_en received on last pattern.

Function
REQ-019 States IDLE, ACTIVE, HALT; registered, Moore outputs only.
REQ-020 IDLE with start=1: next edge loads pattern_addr=0, pattern_word=SEED, shift register=SEED, shift_cnt=0, overrun=0, state ACTIVE; scan_in valid the cycle after start, zero added latency vs controller SHIFT_IN.
REQ-021 ACTIVE, scan_en=1, addr_en=0: shift register rotates right by one (bit 0 to MSB), shift_cnt increments modulo SCAN_LENGTH; after SCAN_LENGTH shifts the register equals pattern_word again.
REQ-022 ACTIVE, addr_en=1, last_pattern=0: pattern_addr+1, pattern_word and shift register load LFSR next, shift_cnt=0.
REQ-023 LFSR next = (pattern_word >> 1) XOR (pattern_word[0] ? TAPS : 0).
REQ-024 addr_en and scan_en same cycle: addr_en wins, no rotate.
REQ-025 ACTIVE, addr_en=1, last_pattern=1: overrun set, pattern_addr and pattern_word hold, state HALT.
REQ-026 ACTIVE or HALT with done=1: state IDLE; pattern_addr, pattern_word, overrun hold; done beats addr_en same cycle.
REQ-027 start ignored outside IDLE; done, scan_en, addr_en ignored in IDLE; scan_en, addr_en ignored in HALT.
REQ-028 NUM_PATTERNS=1: last_pattern high throughout ACTIVE.

Reset
REQ-029 rst=1 at any edge, including mid-shift: state IDLE, pattern_addr=0, pattern_word=SEED, shift register=SEED, shift_cnt=0, overrun=0, busy=0, last_pattern=0; rst overrides start.

Structure
REQ-030 Package bist_pkg holds state encoding and default TAPS per SCAN_LENGTH 2..16.
REQ-031 Sub-module bist_lfsr (combinational next-state, parameterised width/taps) is instantiated once.

Verification
REQ-032 Reset, start pulse, 4 scan_en cycles -> scan_in 1,0,0,0; shift_cnt 1,2,3,0; pattern_word=4'h1.
REQ-033 Four addr_en pulses from start -> pattern_word 4'hC, 4'h6, 4'h3, 4'hD; pattern_addr 1..4.
REQ-034 NUM_PATTERNS=2: one addr_en -> last_pattern=1; second addr_en -> overrun=1, state HALT, pattern_addr stays 1.
REQ-035 scan_en and addr_en same cycle at pattern 4'h1 -> pattern_word=4'hC, shift_cnt=0, no rotation.
REQ-036 rst after 2 shifts -> all outputs at reset values next cycle; new start restarts at SEED.
REQ-037 done during ACTIVE -> busy=0 next cycle, pattern_addr holds; start while ACTIVE -> no change.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern generator: FSM state encoding and
// default Galois LFSR feedback masks for pattern widths 2..16.
package bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HALT   = 2'd2
   } bist_state_e;

   // Right-shifting Galois masks; each gives a maximal-length sequence.
   function automatic logic [15:0] default_taps(input int unsigned width);
      logic [15:0] taps;
      case (width)
         2:       taps = 16'h0003;
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         16:      taps = 16'hD008;
         default: taps = 16'h000C;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Combinational next-state of a right-shifting Galois LFSR.
module bist_lfsr #(
   parameter int unsigned          WIDTH = 4,
   parameter logic [WIDTH-1:0]     TAPS  = 4'hC
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
   end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST pattern source: walks an LFSR sequence of pattern words and serialises
// each through a rotating shift register under control of the BIST controller.
module bist_pattern_gen
   import bist_pkg::*;
#(
   parameter int unsigned              ADDR_WIDTH   = 4,
   parameter int unsigned              SCAN_LENGTH  = 4,
   parameter int unsigned              NUM_PATTERNS = 2 ** ADDR_WIDTH,
   parameter logic [SCAN_LENGTH-1:0]   SEED         = 1,
   parameter logic [SCAN_LENGTH-1:0]   TAPS         = SCAN_LENGTH'(default_taps(SCAN_LENGTH))
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            scan_en,
   input  logic                            addr_en,
   input  logic                            done,
   output logic                            scan_in,
   output logic [SCAN_LENGTH-1:0]          pattern_word,
   output logic [ADDR_WIDTH-1:0]           pattern_addr,
   output logic                            last_pattern,
   output logic [$clog2(SCAN_LENGTH)-1:0]  shift_cnt,
   output logic                            busy,
   output logic                            overrun
);

   localparam int unsigned CW = $clog2(SCAN_LENGTH);

   bist_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [SCAN_LENGTH-1:0]  word_q, word_d;
   logic [SCAN_LENGTH-1:0]  sr_q, sr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    ovr_q, ovr_d;
   logic [SCAN_LENGTH-1:0]  lfsr_next;
   logic                    last;

   bist_lfsr #(
      .WIDTH (SCAN_LENGTH),
      .TAPS  (TAPS)
   ) u_lfsr (
      .cur (word_q),
      .nxt (lfsr_next)
   );

   assign last = (state_q == ST_ACTIVE) && (addr_q == ADDR_WIDTH'(NUM_PATTERNS - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACTIVE;
               addr_d  = '0;
               word_d  = SEED;
               sr_d    = SEED;
               cnt_d   = '0;
               ovr_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // Priority: done, then addr_en, then scan_en.
            if (done) begin
               state_d = ST_IDLE;
            end else if (addr_en) begin
               if (last) begin
                  ovr_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
                  word_d = lfsr_next;
                  sr_d   = lfsr_next;
                  cnt_d  = '0;
               end
            end else if (scan_en) begin
               sr_d  = {sr_q[0], sr_q[SCAN_LENGTH-1:1]};
               cnt_d = (cnt_q == CW'(SCAN_LENGTH - 1)) ? '0 : cnt_q + CW'(1);
            end
         end
         ST_HALT: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         word_q  <= SEED;
         sr_q    <= SEED;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   assign scan_in      = sr_q[0];
   assign pattern_word = word_q;
   assign pattern_addr = addr_q;
   assign last_pattern = last;
   assign shift_cnt    = cnt_q;
   assign busy         = (state_q == ST_ACTIVE);
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed self-checking bench for bist_pattern_gen (default build plus a
// two-pattern build sharing the same stimulus).
module tb_bist_pattern_gen;

   logic       clk = 1'b0;
   logic       rst, start, scan_en, addr_en, done;

   logic       scan_in, last_pattern, busy, overrun;
   logic [3:0] pattern_word, pattern_addr;
   logic [1:0] shift_cnt;

   logic       scan_in2, last2, busy2, ovr2;
   logic [3:0] word2, addr2;
   logic [1:0] cnt2;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   bist_pattern_gen dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .scan_en      (scan_en),
      .addr_en      (addr_en),
      .done         (done),
      .scan_in      (scan_in),
      .pattern_word (pattern_word),
      .pattern_addr (pattern_addr),
      .last_pattern (last_pattern),
      .shift_cnt    (shift_cnt),
      .busy         (busy),
      .overrun      (overrun)
   );

   bist_pattern_gen #(
      .NUM_PATTERNS (2)
   ) dut2 (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .scan_en      (scan_en),
      .addr_en      (addr_en),
      .done         (done),
      .scan_in      (scan_in2),
      .pattern_word (word2),
      .pattern_addr (addr2),
      .last_pattern (last2),
      .shift_cnt    (cnt2),
      .busy         (busy2),
      .overrun      (ovr2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; scan_en = 0; addr_en = 0; done = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_addr"}, pattern_addr, 0);
      check({pfx, "_word"}, pattern_word, 4'h1);
      check({pfx, "_cnt"}, shift_cnt, 0);
      check({pfx, "_ovr"}, overrun, 0);
      check({pfx, "_last"}, last_pattern, 0);
      check({pfx, "_scan_in"}, scan_in, 1);
   endtask

   task automatic do_start();
      start = 1;
      step();
      start = 0;
   endtask

   initial begin
      logic [3:0] exp_words [4];
      exp_words = '{4'hC, 4'h6, 4'h3, 4'hD};

      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      check_reset_values("rst");

      // Start then four shifts of the seed pattern.
      do_start();
      check("start_busy", busy, 1);
      check("start_scan_in", scan_in, 1);
      check("start_cnt", shift_cnt, 0);
      for (int i = 0; i < 4; i++) begin
         scan_en = 1;
         check($sformatf("shift%0d_scan_in", i), scan_in, (i == 0) ? 1 : 0);
         step();
         check($sformatf("shift%0d_cnt", i), shift_cnt, (i + 1) % 4);
      end
      scan_en = 0;
      check("shift_word", pattern_word, 4'h1);
      check("shift_wrap_scan_in", scan_in, 1);

      // LFSR walk.
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) begin
         addr_en = 1;
         step();
         check($sformatf("walk%0d_word", i), pattern_word, exp_words[i]);
         check($sformatf("walk%0d_addr", i), pattern_addr, i + 1);
      end
      addr_en = 0;
      check("walk_last", last_pattern, 0);

      // scan_en and addr_en together after one shift: addr_en wins.
      do_reset();
      do_start();
      scan_en = 1;
      step();
      check("both_pre_cnt", shift_cnt, 1);
      addr_en = 1;
      step();
      scan_en = 0; addr_en = 0;
      check("both_word", pattern_word, 4'hC);
      check("both_cnt", shift_cnt, 0);
      check("both_scan_in", scan_in, 0);

      // Reset mid-shift, with start asserted alongside reset.
      do_reset();
      do_start();
      scan_en = 1;
      step();
      step();
      scan_en = 0;
      check("mid_cnt", shift_cnt, 2);
      rst = 1; start = 1;
      step();
      rst = 0; start = 0;
      check_reset_values("midrst");
      do_start();
      check("restart_busy", busy, 1);
      check("restart_word", pattern_word, 4'h1);
      check("restart_addr", pattern_addr, 0);

      // Start ignored while ACTIVE; done returns to IDLE holding state.
      addr_en = 1;
      step();
      addr_en = 0;
      start = 1;
      step();
      start = 0;
      check("start_active_word", pattern_word, 4'hC);
      check("start_active_addr", pattern_addr, 1);
      done = 1; addr_en = 1;
      step();
      done = 0; addr_en = 0;
      check("done_busy", busy, 0);
      check("done_addr", pattern_addr, 1);
      check("done_word", pattern_word, 4'hC);
      scan_en = 1; addr_en = 1;
      step();
      scan_en = 0; addr_en = 0;
      check("idle_ignore_addr", pattern_addr, 1);
      check("idle_ignore_cnt", shift_cnt, 0);

      // Two-pattern build: last pattern, overrun, HALT.
      do_reset();
      do_start();
      check("np2_last0", last2, 0);
      addr_en = 1;
      step();
      addr_en = 0;
      check("np2_last1", last2, 1);
      check("np2_addr1", addr2, 1);
      addr_en = 1;
      step();
      addr_en = 0;
      check("np2_ovr", ovr2, 1);
      check("np2_halt_busy", busy2, 0);
      check("np2_halt_addr", addr2, 1);
      check("np2_halt_word", word2, 4'hC);
      check("np2_halt_last", last2, 0);
      start = 1;
      step();
      start = 0;
      check("np2_halt_start_ignored", busy2, 0);
      done = 1;
      step();
      done = 0;
      check("np2_done_ovr_hold", ovr2, 1);
      do_start();
      check("np2_restart_ovr", ovr2, 0);
      check("np2_restart_busy", busy2, 1);
      check("np2_restart_addr", addr2, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
